b13_serial_rx: RTL and testbench
================================

# b13_serial_rx

Serial receiver for the b13 transmitter's line protocol. The transmitter drives the line high when idle and between bits. It emits each symbol as a single-cycle value once every BIT_PERIOD clocks: start = 0, then data bits MSB first, then stop = 1. This block detects the start pulse, samples the eight data bits and the stop bit on the same grid, and hands the byte out through a valid/ack register. It reports framing and overrun errors and drives `dsr` back to the transmitter as its ready indication.

## Interface
- `BIT_PERIOD`, 106: clocks between consecutive symbols; must be ≥ 2.
- `CNT_W`, 10: width of the bit-period counter; must satisfy 2^CNT_W > BIT_PERIOD.

Clock and reset: one clock; reset is synchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  line from transmitter `data_out`; idle 1.
- `rx_ack`  in  1  consumer has taken `rx_data`.
- `rx_data`  out  8  last accepted byte.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_end`  out  1  one-cycle pulse at every stop-bit sample.
- `frame_err`  out  1  result of the last stop check: 1 = stop bit sampled 0.
- `overrun`  out  1  a good frame was dropped because `rx_valid` was held.
- `dsr`  out  1  ready to receive.
- `busy`  out  1  frame in progress (state ≠ IDLE).

## Operation
- Reset values:
  - state IDLE; bit counter 0; bit index 0; shift register 0.
  - `rx_data`=0, `rx_valid`=0, `rx_end`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - `dsr`=0 while `reset`=1.
- A reset edge mid-frame aborts the frame and discards all partial data.
- States: IDLE, DATA, STOP.
- IDLE:
  - On an edge with `serial_in`=0: counter←0, index←0, go to DATA.
  - Otherwise stay.
- DATA:
  - If counter == BIT_PERIOD-1: shift←{shift[6:0], `serial_in`}, counter←0, index←index+1.
  - Else counter←counter+1.
  - After the 8th sample, go to STOP.
  - `serial_in` values between sample edges are ignored.
- STOP: same counting rule. At the sample edge:
  - `rx_end`←1 for one cycle; return to IDLE.
  - If `serial_in`=0: `frame_err`←1. The byte is discarded; `rx_valid`, `rx_data` and `overrun` are unchanged.
  - If `serial_in`=1: `frame_err`←0, then:
    - `rx_valid`=0, or `rx_valid`=1 with `rx_ack`=1: `rx_data`←shift, `rx_valid`←1, `overrun`←0.
    - `rx_valid`=1 with `rx_ack`=0: the new byte is dropped, `overrun`←1, `rx_data` unchanged.
- Ack: on an edge with `rx_valid`=1 and `rx_ack`=1 and no byte loaded that edge, `rx_valid`←0. `rx_ack` while `rx_valid`=0 is ignored.
- `dsr` = ~`reset` & (state==IDLE) & ~`rx_valid`. It is combinational from registers and `reset`.
- `busy` = (state≠IDLE).
- All other outputs are registered.
- Counter arithmetic is unsigned CNT_W bits. It never exceeds BIT_PERIOD-1, so it never wraps.

## Timing
- Start detected at edge T, meaning `serial_in`=0 is sampled while in IDLE.
- Data bit k (k=0 is the MSB) is sampled at edge T+(k+1)·BIT_PERIOD.
- The stop bit is sampled at edge T+9·BIT_PERIOD. `rx_valid`, `rx_data`, `frame_err`, `overrun` and `rx_end` update at that edge.
- Latency from start edge to byte valid: 9·BIT_PERIOD clocks (954 at default).
- IDLE is re-entered after the stop edge. The earliest next start is detected at edge T+9·BIT_PERIOD+1.
- `rx_end` is high for exactly the one cycle after the stop edge.
- Simultaneous events at the stop edge:
  - `rx_ack`=1 together with a good stop: the new byte loads, `rx_valid` stays 1, no overrun.
  - `rx_ack`=1 together with a bad stop: `rx_valid`←0, `frame_err`←1.

## Test plan
- **Nominal frame.** Reset for 2 cycles. Send 0xA5 with start sampled at edge 10.
  - Required at edge 964: `rx_valid`=1, `rx_data`=0xA5, `frame_err`=0, `rx_end` pulses once.
  - `dsr`=0 from edge 10 until `rx_ack`; `dsr`=1 on the edge after `rx_ack`.
- **Framing error.** Send 0x3C with `serial_in`=0 at the stop sample edge.
  - Required: `frame_err`=1, `rx_valid`=0, `rx_end` pulses.
  - A following good 0x3C sets `frame_err`=0 and `rx_data`=0x3C.
- **Overrun.** Send 0x3C then 0xC3 with no ack.
  - Required after the second stop: `rx_data`=0x3C, `overrun`=1.
  - Then ack and send 0x55. Required: `rx_data`=0x55, `overrun`=0.
- **Coincident ack.** Hold 0x11 unacked. Assert `rx_ack` exactly on the stop edge of frame 0x22.
  - Required: `rx_data`=0x22, `rx_valid`=1, `overrun`=0.
- **Reset mid-frame.** Assert reset after bit 4 of a frame; release it.
  - Required: IDLE, all outputs at reset values.
  - A subsequent 0x81 is received correctly with no error flags.
- **Back-to-back frames.** Start the second frame at edge T+9·BIT_PERIOD+1, sending 0xFF then 0x00 with acks.
  - Required: both bytes received in order, no errors.
  - Also run the test with BIT_PERIOD=4.

Source files
------------

// File: rtl/b13_serial_rx.sv
// b13_serial_rx: receiver for the b13 transmitter line. Samples one symbol
// every BIT_PERIOD clocks after the start pulse (8 data bits MSB first, then
// stop) and presents the byte on a valid/ack register with error flags.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle, waiting for a 0 sample (start pulse)
// DATA  | counting bit periods, shifting in the eight data bits
// STOP  | one more bit period, then check stop and hand off the byte
module b13_serial_rx #(
  parameter int BIT_PERIOD = 106,
  parameter int CNT_W      = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_end,
  output logic       frame_err,
  output logic       overrun,
  output logic       dsr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_PERIOD - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_end_q, rx_end_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic               sample_edge;
  logic               load_byte;

  assign sample_edge = (cnt_q == LAST_CNT);

  // Next-state and next-output computation for the whole receiver.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_end_d    = 1'b0;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    load_byte   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (sample_edge) begin
          shift_d = {shift_q[6:0], serial_in};
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (sample_edge) begin
          cnt_d    = '0;
          rx_end_d = 1'b1;
          state_d  = IDLE;
          if (!serial_in) begin
            // Bad stop: byte thrown away, holding register left alone.
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b0;
            if (!rx_valid_q || rx_ack) begin
              load_byte  = 1'b1;
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              overrun_d  = 1'b0;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A consumer ack frees the register unless a new byte lands on the same edge.
    if (rx_valid_q && rx_ack && !load_byte) begin
      rx_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_end_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_end_q    <= rx_end_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_end    = rx_end_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  // Ready only when idle with an empty holding register, and never in reset.
  assign dsr       = ~reset & (state_q == IDLE) & ~rx_valid_q;

endmodule

// File: tb/tb_b13_serial_rx.sv
// Bench for b13_serial_rx: directed frame table at BIT_PERIOD=106, a
// mid-frame reset sequence, then randomized frames at 106 and at 4 checked
// against a frame-level model of the holding register and error flags.
module tb_b13_serial_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;
  logic rx_ack = 1'b0;

  logic [7:0] d_a, d_b;
  logic v_a, e_a, f_a, o_a, r_a, b_a;
  logic v_b, e_b, f_b, o_b, r_b, b_b;

  b13_serial_rx #(.BIT_PERIOD(106), .CNT_W(10)) u_dut_106 (
    .clock(clock), .reset(reset), .serial_in(serial_in), .rx_ack(rx_ack),
    .rx_data(d_a), .rx_valid(v_a), .rx_end(e_a), .frame_err(f_a),
    .overrun(o_a), .dsr(r_a), .busy(b_a)
  );

  b13_serial_rx #(.BIT_PERIOD(4), .CNT_W(3)) u_dut_4 (
    .clock(clock), .reset(reset), .serial_in(serial_in), .rx_ack(rx_ack),
    .rx_data(d_b), .rx_valid(v_b), .rx_end(e_b), .frame_err(f_b),
    .overrun(o_b), .dsr(r_b), .busy(b_b)
  );

  // Observation mux: which instance the current test is talking to.
  bit sel4 = 1'b0;
  int bp = 106;
  logic [7:0] o_data;
  logic o_valid, o_end, o_ferr, o_ovr, o_dsr, o_busy;
  assign o_data  = sel4 ? d_b : d_a;
  assign o_valid = sel4 ? v_b : v_a;
  assign o_end   = sel4 ? e_b : e_a;
  assign o_ferr  = sel4 ? f_b : f_a;
  assign o_ovr   = sel4 ? o_b : o_a;
  assign o_dsr   = sel4 ? r_b : r_a;
  assign o_busy  = sel4 ? b_b : b_a;

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model of the consumer-visible register.
  logic [7:0] m_data;
  bit m_valid, m_ferr, m_ovr;

  typedef struct {
    logic [7:0] b;
    bit         stop;
    bit         ack_stop;
    bit         b2b;
    int         ack_gap;
    logic [7:0] ed;
    bit         ev;
    bit         ef;
    bit         eo;
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // Outputs in reset/after reset: {data, valid, end, ferr, ovr, busy}.
  task automatic check_reset_outputs(input string name, input bit exp_dsr);
    cmp(name, 32'({o_data, o_valid, o_end, o_ferr, o_ovr, o_busy, o_dsr}),
        32'({8'h00, 5'b00000, exp_dsr}));
  endtask

  // Send one frame starting at the current negedge (start sampled next edge).
  // Between sample edges the line carries noise, which must be ignored.
  task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit ack_stop,
                            input int abort_e);
    bit ok;
    int k;
    ok = 1'b1;
    serial_in = 1'b0;
    rx_ack = 1'b0;
    for (int e = 1; e <= 9 * bp; e++) begin
      @(negedge clock);
      if (o_busy !== 1'b1 || o_dsr !== 1'b0 || o_end !== 1'b0) ok = 1'b0;
      if (e == abort_e) begin
        cmp("in_frame_busy_dsr", 32'(ok), 32'(1));
        reset = 1'b1;
        serial_in = 1'($urandom_range(0, 1));
        @(negedge clock);
        check_reset_outputs("reset_midframe_in_reset", 1'b0);
        @(negedge clock);
        reset = 1'b0;
        serial_in = 1'b1;
        @(negedge clock);
        check_reset_outputs("reset_midframe_released", 1'b1);
        model_reset();
        return;
      end
      if (e % bp == 0) begin
        k = e / bp;
        serial_in = (k == 9) ? stop_b : b[8 - k];
      end else begin
        serial_in = 1'($urandom_range(0, 1));
      end
      rx_ack = (e == 9 * bp) ? ack_stop : 1'b0;
    end
    cmp("in_frame_busy_dsr", 32'(ok), 32'(1));
    @(negedge clock);
    serial_in = 1'b1;
    rx_ack = 1'b0;
    if (!stop_b) begin
      m_ferr = 1'b1;
      if (ack_stop && m_valid) m_valid = 1'b0;
    end else begin
      m_ferr = 1'b0;
      if (!m_valid || ack_stop) begin
        m_data = b; m_valid = 1'b1; m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // Right after a stop edge: rx_end high, idle, register contents as given.
  task automatic check_frame(input string name, input logic [7:0] ed, input bit ev,
                             input bit ef, input bit eo);
    cmp({name, "_out"}, 32'({o_end, o_busy, o_data, o_valid, o_ferr, o_ovr}),
        32'({1'b1, 1'b0, ed, ev, ef, eo}));
    cmp({name, "_dsr"}, 32'(o_dsr), 32'(!ev));
  endtask

  // Idle line for n cycles, optional single-cycle ack at cycle ackcyc.
  task automatic idle(input int n, input int ackcyc);
    for (int i = 0; i < n; i++) begin
      serial_in = 1'b1;
      rx_ack = (i == ackcyc);
      @(negedge clock);
      if (i == 0) cmp("rx_end_one_cycle", 32'(o_end), 32'(0));
    end
    rx_ack = 1'b0;
    if (ackcyc >= 0 && ackcyc < n) m_valid = 1'b0;
    cmp("idle_valid_dsr", 32'({o_busy, o_valid, o_dsr}), 32'({1'b0, m_valid, !m_valid}));
  endtask

  task automatic random_frames(input int count);
    logic [7:0] b;
    bit stop_b, acks;
    int gap;
    for (int i = 0; i < count; i++) begin
      b = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      acks = ($urandom_range(0, 3) == 0);
      send_frame(b, stop_b, acks, 0);
      check_frame("rand_frame", m_data, m_valid, m_ferr, m_ovr);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap, ($urandom_range(0, 1) != 0) ? $urandom_range(0, gap - 1) : -1);
    end
  endtask

  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0,  0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h3C, 1'b0, 1'b0, 1'b0, -1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'h3C, 1'b1, 1'b0, 1'b0, -1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'hC3, 1'b1, 1'b0, 1'b0,  0, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'h55, 1'b1, 1'b0, 1'b0,  0, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h11, 1'b1, 1'b0, 1'b0, -1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h22, 1'b1, 1'b1, 1'b0,  0, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 1'b1, 1'b0, 1'b1, -1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 1'b1, 1'b1, 1'b0,  0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h5A, 1'b1, 1'b0, 1'b0, -1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h77, 1'b0, 1'b1, 1'b0, -1, 8'h5A, 1'b0, 1'b1, 1'b0};

    model_reset();
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("reset_state", 1'b0);
    @(negedge clock);
    reset = 1'b0;
    while (edge_cnt < 9) @(negedge clock);
    cmp("idle_dsr_after_reset", 32'({o_dsr, o_busy}), 32'({1'b1, 1'b0}));

    // Directed table at BIT_PERIOD=106; first row starts at edge 10.
    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].ack_stop, 0);
      if (i == 0) cmp("nominal_stop_edge", 32'(edge_cnt), 32'(964));
      check_frame($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev, vecs[i].ef, vecs[i].eo);
      if (!vecs[i].b2b) idle(4, vecs[i].ack_gap);
    end

    // Reset after bit 4, then a clean 0x81.
    send_frame(8'h96, 1'b1, 1'b0, 5 * 106 + 3);
    idle(3, -1);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    check_frame("after_reset_81", 8'h81, 1'b1, 1'b0, 1'b0);
    idle(2, 0);

    random_frames(4);

    // Switch to the BIT_PERIOD=4 instance.
    sel4 = 1'b1;
    bp = 4;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("bp4_reset_state", 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);

    send_frame(8'hFF, 1'b1, 1'b0, 0);
    check_frame("bp4_b2b_ff", 8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b1, 0);
    check_frame("bp4_b2b_00", 8'h00, 1'b1, 1'b0, 1'b0);
    idle(3, 0);

    send_frame(8'hA5, 1'b1, 1'b0, 4 * 5 + 2);
    idle(2, -1);

    random_frames(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
